// File: rtl/count_check_pkg.sv
// Shared types and counter widths for the count sequence checker.
package count_check_pkg;

   localparam int ERR_CNT_W  = 8;
   localparam int WRAP_CNT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_LOCKED  = 2'd2,
      ST_FAULT   = 2'd3
   } state_e;

endpackage

// File: rtl/count_check_satcnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module count_check_satcnt
   import count_check_pkg::*;
#(
   parameter int W = ERR_CNT_W
) (
   input  logic         clock_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_d;
   logic [W-1:0] count_q;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != {W{1'b1}})) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(negedge clock_n) begin
      count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/count_sequence_checker.sv
// Checks that a counter bus increments by one each falling edge; locks, counts errors/wraps, faults.
// Optional: COUNT_CHECK_RESYNC_EN treats an unexpected q==0 while locked as a counter restart.
module count_sequence_checker
   import count_check_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int LOCK_COUNT = 2,
   parameter int ERR_LIMIT  = 3
) (
   input  logic                  clock_n,
   input  logic                  reset,
   input  logic [WIDTH-1:0]      q,
   input  logic                  enable,
   output logic                  locked,
   output logic                  err_pulse,
   output logic [ERR_CNT_W-1:0]  err_count,
   output logic [WRAP_CNT_W-1:0] wrap_count,
   output logic [1:0]            state
);

`ifdef COUNT_CHECK_RESYNC_EN
   localparam bit RESYNC_EN = 1'b1;
`else
   localparam bit RESYNC_EN = 1'b0;
`endif

   localparam int GOOD_W = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
   localparam int BAD_W  = (ERR_LIMIT < 1) ? 1 : $clog2(ERR_LIMIT + 1);
   localparam logic [GOOD_W-1:0] LOCK_LIM = GOOD_W'(LOCK_COUNT);
   localparam logic [BAD_W-1:0]  ERR_LIM  = BAD_W'(ERR_LIMIT);

   state_e                  state_d, state_q;
   logic [WIDTH-1:0]        q_prev_d, q_prev_q;
   logic [GOOD_W-1:0]       good_run_d, good_run_q;
   logic [BAD_W-1:0]        bad_run_d, bad_run_q;
   logic                    err_pulse_d, err_pulse_q;
   logic                    locked_d, locked_q;
   logic [WRAP_CNT_W-1:0]   wrap_count_d, wrap_count_q;
   logic                    err_inc;
   logic [WIDTH-1:0]        expected;
   logic                    match;
   logic [GOOD_W-1:0]       good_inc;
   logic [BAD_W-1:0]        bad_inc;

   assign expected = q_prev_q + WIDTH'(1);
   assign match    = (q == expected);
   assign good_inc = good_run_q + GOOD_W'(1);
   assign bad_inc  = bad_run_q + BAD_W'(1);

   always_comb begin
      state_d      = state_q;
      q_prev_d     = q_prev_q;
      good_run_d   = good_run_q;
      bad_run_d    = bad_run_q;
      err_pulse_d  = 1'b0;
      wrap_count_d = wrap_count_q;
      err_inc      = 1'b0;
      // Dropping enable wins over any same-edge decision, so nothing is counted.
      if (!enable) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               q_prev_d   = q;
               good_run_d = '0;
               state_d    = ST_ACQUIRE;
            end
            ST_ACQUIRE: begin
               q_prev_d = q;
               if (match) begin
                  good_run_d = good_inc;
                  if (good_inc == LOCK_LIM) begin
                     state_d   = ST_LOCKED;
                     bad_run_d = '0;
                  end
               end else begin
                  good_run_d = '0;
               end
            end
            ST_LOCKED: begin
               q_prev_d = q;
               if (match) begin
                  bad_run_d = '0;
                  if (q == '0) begin
                     wrap_count_d = wrap_count_q + WRAP_CNT_W'(1);
                  end
               end else if (RESYNC_EN && (q == '0)) begin
                  bad_run_d = '0;
               end else begin
                  err_pulse_d = 1'b1;
                  err_inc     = 1'b1;
                  bad_run_d   = bad_inc;
                  if (bad_inc == ERR_LIM) begin
                     state_d = ST_FAULT;
                  end
               end
            end
            default: begin
               state_d = ST_FAULT;
            end
         endcase
      end
      locked_d = (state_d == ST_LOCKED);
   end

   always_ff @(negedge clock_n) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         q_prev_q     <= '0;
         good_run_q   <= '0;
         bad_run_q    <= '0;
         err_pulse_q  <= 1'b0;
         locked_q     <= 1'b0;
         wrap_count_q <= '0;
      end else begin
         state_q      <= state_d;
         q_prev_q     <= q_prev_d;
         good_run_q   <= good_run_d;
         bad_run_q    <= bad_run_d;
         err_pulse_q  <= err_pulse_d;
         locked_q     <= locked_d;
         wrap_count_q <= wrap_count_d;
      end
   end

   count_check_satcnt #(
      .W (ERR_CNT_W)
   ) u_err_cnt (
      .clock_n (clock_n),
      .clr     (reset),
      .inc     (err_inc),
      .count   (err_count)
   );

   assign locked     = locked_q;
   assign err_pulse  = err_pulse_q;
   assign wrap_count = wrap_count_q;
   assign state      = state_q;

endmodule
